// File: rtl/control_sequencer.sv
// control_sequencer
// Hardwired control unit for the Mini SRC CPU. A state register walks the
// fetch / decode / execute sequence. Every datapath control output is decoded
// combinationally from the state, the instruction word in IR and, inside the
// two memory wait states, mem_done.
//
// Ports
//   clock          system clock, rising-edge active
//   clear          asynchronous active-low reset
//   run            permits a new fetch; sampled in IDLE and at instruction end
//   ir[31:0]       IR contents: op=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15]
//   mem_done       memory completes the current read/write this cycle
//   e_*            datapath register enables
//   incPC          PC increment
//   MDR_read       1 = MDR loads from memory, 0 = from the bus
//   GP_addr[3:0]   register-file write index
//   ALU_op[3:0]    ALU operation select
//   BusDataSelect  bus source: 0-15 R0-R15, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR
//   mem_read/write memory request strobes
//   halted         high while in HALT
//   illegal        one-cycle pulse when an unassigned opcode is decoded
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_done,
  output logic        e_PC,
  output logic        e_IR,
  output logic        e_Y,
  output logic        e_Z,
  output logic        e_HI,
  output logic        e_LO,
  output logic        e_MDR,
  output logic        e_MAR,
  output logic        e_GP,
  output logic        incPC,
  output logic        MDR_read,
  output logic [3:0]  GP_addr,
  output logic [3:0]  ALU_op,
  output logic [4:0]  BusDataSelect,
  output logic        mem_read,
  output logic        mem_write,
  output logic        halted,
  output logic        illegal
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] BUS_HI    = 5'd16;
  localparam logic [4:0] BUS_ZHIGH = 5'd18;
  localparam logic [4:0] BUS_ZLOW  = 5'd19;
  localparam logic [4:0] BUS_PC    = 5'd20;
  localparam logic [4:0] BUS_MDR   = 5'd21;

  typedef enum logic [3:0] {
    IDLE, F0, F1, F2, T3, T4, T5, T6, HALT
  } state_t;

  state_t state;
  state_t end_state;

  logic [4:0] op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       unused_ir;

  assign op = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];
  // The low IR bits carry immediates the sequencer never looks at.
  assign unused_ir = ^ir[14:0];

  // Instruction class decode
  logic       is_alu2;
  logic       is_unary;
  logic       is_muldiv;
  logic       is_ld;
  logic       is_st;
  logic       is_nop;
  logic       is_halt;
  logic       is_legal;
  logic [3:0] alu_code;

  always_comb begin
    is_alu2   = 1'b0;
    is_unary  = 1'b0;
    is_muldiv = 1'b0;
    is_ld     = 1'b0;
    is_st     = 1'b0;
    is_nop    = 1'b0;
    is_halt   = 1'b0;
    alu_code  = 4'd0;
    case (op)
      OP_ADD:  begin is_alu2   = 1'b1; alu_code = 4'd0;  end
      OP_SUB:  begin is_alu2   = 1'b1; alu_code = 4'd1;  end
      OP_AND:  begin is_alu2   = 1'b1; alu_code = 4'd2;  end
      OP_OR:   begin is_alu2   = 1'b1; alu_code = 4'd3;  end
      OP_SHR:  begin is_alu2   = 1'b1; alu_code = 4'd4;  end
      OP_SHL:  begin is_alu2   = 1'b1; alu_code = 4'd5;  end
      OP_ROR:  begin is_alu2   = 1'b1; alu_code = 4'd6;  end
      OP_ROL:  begin is_alu2   = 1'b1; alu_code = 4'd7;  end
      OP_MUL:  begin is_muldiv = 1'b1; alu_code = 4'd8;  end
      OP_DIV:  begin is_muldiv = 1'b1; alu_code = 4'd9;  end
      OP_NEG:  begin is_unary  = 1'b1; alu_code = 4'd10; end
      OP_NOT:  begin is_unary  = 1'b1; alu_code = 4'd11; end
      OP_LD:   is_ld   = 1'b1;
      OP_ST:   is_st   = 1'b1;
      OP_NOP:  is_nop  = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  assign is_legal = is_alu2 | is_unary | is_muldiv | is_ld | is_st | is_nop | is_halt;

  // Where every instruction goes after its last execute cycle.
  assign end_state = is_halt ? HALT : (run ? F0 : IDLE);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (run) state <= F0;
        F0:   state <= F1;
        F1:   if (mem_done) state <= F2;
        F2:   state <= T3;
        T3: begin
          if (is_alu2 | is_unary | is_muldiv | is_ld | is_st) state <= T4;
          else                                                 state <= end_state;
        end
        T4: begin
          if (is_unary)   state <= end_state;
          else if (is_ld) begin
            if (mem_done) state <= T5;
          end else        state <= T5;
        end
        T5: begin
          if (is_muldiv)  state <= T6;
          else if (is_st) begin
            if (mem_done) state <= end_state;
          end else        state <= end_state;
        end
        T6:   state <= end_state;
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    e_PC          = 1'b0;
    e_IR          = 1'b0;
    e_Y           = 1'b0;
    e_Z           = 1'b0;
    e_HI          = 1'b0;
    e_LO          = 1'b0;
    e_MDR         = 1'b0;
    e_MAR         = 1'b0;
    e_GP          = 1'b0;
    incPC         = 1'b0;
    MDR_read      = 1'b0;
    GP_addr       = 4'd0;
    ALU_op        = 4'd0;
    BusDataSelect = 5'd0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    halted        = 1'b0;
    illegal       = 1'b0;
    case (state)
      F0: begin
        BusDataSelect = BUS_PC;
        e_MAR         = 1'b1;
        incPC         = 1'b1;
      end
      F1: begin
        // Request stays up through the completing cycle; data latches then.
        mem_read = 1'b1;
        MDR_read = mem_done;
        e_MDR    = mem_done;
      end
      F2: begin
        BusDataSelect = BUS_MDR;
        e_IR          = 1'b1;
      end
      T3: begin
        if (is_alu2) begin
          BusDataSelect = {1'b0, rb};
          e_Y           = 1'b1;
        end else if (is_unary) begin
          BusDataSelect = {1'b0, rb};
          ALU_op        = alu_code;
          e_Z           = 1'b1;
        end else if (is_muldiv) begin
          BusDataSelect = {1'b0, ra};
          e_Y           = 1'b1;
        end else if (is_ld | is_st) begin
          BusDataSelect = {1'b0, rb};
          e_MAR         = 1'b1;
        end else if (!is_legal) begin
          // T3 is visited once per instruction, so this is a single-cycle pulse.
          illegal = 1'b1;
        end
      end
      T4: begin
        if (is_alu2) begin
          BusDataSelect = {1'b0, rc};
          ALU_op        = alu_code;
          e_Z           = 1'b1;
        end else if (is_unary) begin
          BusDataSelect = BUS_ZLOW;
          e_GP          = 1'b1;
          GP_addr       = ra;
        end else if (is_muldiv) begin
          BusDataSelect = {1'b0, rb};
          ALU_op        = alu_code;
          e_Z           = 1'b1;
        end else if (is_ld) begin
          mem_read = 1'b1;
          MDR_read = mem_done;
          e_MDR    = mem_done;
        end else if (is_st) begin
          BusDataSelect = {1'b0, ra};
          e_MDR         = 1'b1;
        end
      end
      T5: begin
        if (is_alu2) begin
          BusDataSelect = BUS_ZLOW;
          e_GP          = 1'b1;
          GP_addr       = ra;
        end else if (is_muldiv) begin
          BusDataSelect = BUS_ZLOW;
          e_LO          = 1'b1;
        end else if (is_ld) begin
          BusDataSelect = BUS_MDR;
          e_GP          = 1'b1;
          GP_addr       = ra;
        end else if (is_st) begin
          mem_write = 1'b1;
        end
      end
      T6: begin
        BusDataSelect = BUS_ZHIGH;
        e_HI          = 1'b1;
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

  // HI is a legal bus source for the datapath but is never selected by this sequence.
  logic [4:0] unused_bus_hi;
  assign unused_bus_hi = BUS_HI;

endmodule
